// File: rtl/mmio_uart_tx.sv
// mmio_uart_tx: snoops core stores on the data-memory port, queues bytes written
// to the TX address in a small circular FIFO, and serialises them as 8N1 frames.
// A status word is returned combinationally for loads from the STATUS address.
module mmio_uart_tx #(
  parameter logic [31:0] TX_ADDR      = 32'hFFFF_FF00,
  parameter logic [31:0] STATUS_ADDR  = 32'hFFFF_FF04,
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        mem_write_i,
  input  logic [31:0] addr_i32,
  input  logic [31:0] write_data_i32,
  output logic [31:0] read_data_o32,
  output logic        hit_o,
  output logic        tx_o,
  output logic        overflow_o
);

  localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W  = PTR_W + 1;
  localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);

  localparam logic [CNT_W-1:0]  DEPTH_C     = CNT_W'(FIFO_DEPTH);
  localparam logic [CNT_W-1:0]  CNT_ZERO_C  = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0]  CNT_ONE_C   = CNT_W'(32'd1);
  localparam logic [PTR_W-1:0]  PTR_ZERO_C  = {PTR_W{1'b0}};
  localparam logic [PTR_W-1:0]  PTR_ONE_C   = PTR_W'(32'd1);
  localparam logic [BAUD_W-1:0] BAUD_ZERO_C = {BAUD_W{1'b0}};
  localparam logic [BAUD_W-1:0] BAUD_ONE_C  = BAUD_W'(32'd1);
  localparam logic [BAUD_W-1:0] BAUD_LAST_C = BAUD_W'(CLKS_PER_BIT - 32'd1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  // Status word layout: busy, full, empty, overflow in the low nibble, count in [15:8].
  function automatic logic [31:0] pack_status(
    input logic       busy,
    input logic       full,
    input logic       empty,
    input logic       ovf,
    input logic [7:0] cnt
  );
    pack_status = {16'h0000, cnt, 4'h0, ovf, empty, full, busy};
  endfunction

  // Registered state
  state_t            state_r;
  logic [BAUD_W-1:0] baud_r;
  logic [2:0]        bit_idx_r;
  logic [7:0]        shift_r;
  logic              tx_r;
  logic              overflow_r;
  logic [7:0]        fifo_mem_r [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_r;
  logic [PTR_W-1:0]  rd_ptr_r;
  logic [CNT_W-1:0]  count_r;

  // Next-state and decode signals
  state_t            state_n_s;
  logic [BAUD_W-1:0] baud_n_s;
  logic [2:0]        bit_idx_n_s;
  logic [7:0]        shift_n_s;
  logic              tx_n_s;
  logic              baud_last_s;
  logic              empty_s;
  logic              full_s;
  logic              busy_s;
  logic              push_s;
  logic              pop_s;
  logic              push_ok_s;
  logic              drop_s;
  logic              clr_s;
  logic [7:0]        head_s;
  logic              unused_upper_s;

  // Only the low byte (and bit0 for the clear) is meaningful; the rest of the store data is ignored.
  assign unused_upper_s = ^write_data_i32[31:8];

  assign empty_s     = (count_r == CNT_ZERO_C);
  assign full_s      = (count_r == DEPTH_C);
  assign busy_s      = (state_r != IDLE) || !empty_s;
  assign baud_last_s = (baud_r == BAUD_LAST_C);
  assign head_s      = fifo_mem_r[rd_ptr_r];

  assign push_s    = mem_write_i && (addr_i32 == TX_ADDR);
  assign pop_s     = (state_r == IDLE) && !empty_s;
  assign push_ok_s = push_s && (!full_s || pop_s);
  assign drop_s    = push_s && full_s && !pop_s;
  assign clr_s     = mem_write_i && (addr_i32 == STATUS_ADDR) && write_data_i32[0];

  assign hit_o      = (addr_i32 == TX_ADDR) || (addr_i32 == STATUS_ADDR);
  assign tx_o       = tx_r;
  assign overflow_o = overflow_r;

  // Status readback for loads; reflects pre-update state so a same-cycle push is not yet counted.
  always_comb begin
    read_data_o32 = 32'h0000_0000;
    if (addr_i32 == STATUS_ADDR) begin
      read_data_o32 = pack_status(busy_s, full_s, empty_s, overflow_r, 8'(count_r));
    end else begin
      read_data_o32 = 32'h0000_0000;
    end
  end

  // Serializer next-state logic; tx_n_s is the line level belonging to the next cycle's state.
  always_comb begin
    state_n_s   = state_r;
    baud_n_s    = baud_r;
    bit_idx_n_s = bit_idx_r;
    shift_n_s   = shift_r;
    tx_n_s      = 1'b1;
    case (state_r)
      IDLE: begin
        baud_n_s    = BAUD_ZERO_C;
        bit_idx_n_s = 3'd0;
        if (pop_s) begin
          state_n_s = START;
          shift_n_s = head_s;
          tx_n_s    = 1'b0;
        end else begin
          tx_n_s = 1'b1;
        end
      end
      START: begin
        tx_n_s = 1'b0;
        if (baud_last_s) begin
          state_n_s   = DATA;
          baud_n_s    = BAUD_ZERO_C;
          bit_idx_n_s = 3'd0;
          tx_n_s      = shift_r[0];
        end else begin
          baud_n_s = baud_r + BAUD_ONE_C;
        end
      end
      DATA: begin
        tx_n_s = shift_r[0];
        if (baud_last_s) begin
          baud_n_s  = BAUD_ZERO_C;
          shift_n_s = {1'b0, shift_r[7:1]};
          if (bit_idx_r == 3'd7) begin
            state_n_s   = STOP;
            bit_idx_n_s = 3'd0;
            tx_n_s      = 1'b1;
          end else begin
            bit_idx_n_s = bit_idx_r + 3'd1;
            tx_n_s      = shift_r[1];
          end
        end else begin
          baud_n_s = baud_r + BAUD_ONE_C;
        end
      end
      STOP: begin
        tx_n_s = 1'b1;
        if (baud_last_s) begin
          state_n_s = IDLE;
          baud_n_s  = BAUD_ZERO_C;
        end else begin
          baud_n_s = baud_r + BAUD_ONE_C;
        end
      end
      default: begin
        state_n_s   = IDLE;
        baud_n_s    = BAUD_ZERO_C;
        bit_idx_n_s = 3'd0;
        tx_n_s      = 1'b1;
      end
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_n_s;
    end
  end

  // Serializer datapath registers, including the glitch-free line driver.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      baud_r    <= BAUD_ZERO_C;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
      tx_r      <= 1'b1;
    end else begin
      baud_r    <= baud_n_s;
      bit_idx_r <= bit_idx_n_s;
      shift_r   <= shift_n_s;
      tx_r      <= tx_n_s;
    end
  end

  // FIFO storage; no reset needed because count gates every read.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      fifo_mem_r[wr_ptr_r] <= write_data_i32[7:0];
    end
  end

  // FIFO pointers and occupancy; a simultaneous push and pop leaves count unchanged.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      wr_ptr_r <= PTR_ZERO_C;
      rd_ptr_r <= PTR_ZERO_C;
      count_r  <= CNT_ZERO_C;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_ONE_C;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_ONE_C;
      end
      if (push_ok_s && !pop_s) begin
        count_r <= count_r + CNT_ONE_C;
      end else if (pop_s && !push_ok_s) begin
        count_r <= count_r - CNT_ONE_C;
      end else begin
        count_r <= count_r;
      end
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear keeps it set.
  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      overflow_r <= 1'b0;
    end else if (drop_s) begin
      overflow_r <= 1'b1;
    end else if (clr_s) begin
      overflow_r <= 1'b0;
    end else begin
      overflow_r <= overflow_r;
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb_mmio_uart_tx: directed stimulus against a frame-timeline model of the UART,
// plus a line receiver and hand-computed literal expectations.
module tb_mmio_uart_tx;

  localparam logic [31:0] TX_A  = 32'hFFFF_FF00;
  localparam logic [31:0] ST_A  = 32'hFFFF_FF04;
  localparam int          CPB   = 4;
  localparam int          DEPTH = 4;
  localparam int          FRAME = 10 * CPB;

  logic        clk       = 1'b0;
  logic        reset_i   = 1'b0;
  logic        mem_write = 1'b0;
  logic [31:0] addr      = 32'h0;
  logic [31:0] wdata     = 32'h0;
  logic [31:0] rd;
  logic        hit;
  logic        tx;
  logic        ovf;

  mmio_uart_tx #(
    .TX_ADDR      (TX_A),
    .STATUS_ADDR  (ST_A),
    .CLKS_PER_BIT (CPB),
    .FIFO_DEPTH   (DEPTH)
  ) dut (
    .clk_i          (clk),
    .reset_i        (reset_i),
    .mem_write_i    (mem_write),
    .addr_i32       (addr),
    .write_data_i32 (wdata),
    .read_data_o32  (rd),
    .hit_o          (hit),
    .tx_o           (tx),
    .overflow_o     (ovf)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endfunction

  // ---------------- behavioural model: queue of bytes + position within current frame
  logic [7:0] m_q[$];
  logic [7:0] m_cur   = 8'h00;
  int         m_ph    = -1;     // -1: line idle, else cycle index 0..FRAME-1 within frame
  bit         m_ovf   = 1'b0;
  bit         m_valid = 1'b0;

  function automatic logic exp_line(int ph, logic [7:0] b);
    int slot;
    if (ph < 0) return 1'b1;
    slot = ph / CPB;
    if (slot == 0) return 1'b0;
    if (slot == 9) return 1'b1;
    return b[slot-1];
  endfunction

  always @(posedge clk) begin : model
    bit do_pop;
    bit do_push;
    bit do_clr;
    bit do_drop;
    if (!reset_i) begin
      m_q.delete();
      m_ph    = -1;
      m_ovf   = 1'b0;
      m_valid = 1'b1;
    end else if (m_valid) begin
      do_pop  = (m_ph < 0) && (m_q.size() > 0);
      do_push = mem_write && (addr == TX_A);
      do_clr  = mem_write && (addr == ST_A) && wdata[0];
      do_drop = 1'b0;
      if (do_pop) m_cur = m_q.pop_front();
      if (do_push) begin
        if (m_q.size() < DEPTH) m_q.push_back(wdata[7:0]);
        else do_drop = 1'b1;
      end
      if (do_clr) m_ovf = 1'b0;
      if (do_drop) m_ovf = 1'b1;
      if (do_pop) m_ph = 0;
      else if (m_ph >= 0) m_ph = (m_ph == FRAME - 1) ? -1 : m_ph + 1;
    end
  end

  // Compare process: every cycle after reset, all outputs against the model.
  always @(negedge clk) begin : compare
    int          cnt;
    logic [31:0] exp_rd;
    bit          busy;
    if (m_valid) begin
      cnt  = m_q.size();
      busy = (m_ph >= 0) || (cnt > 0);
      exp_rd = 32'h0;
      if (addr == ST_A)
        exp_rd = {16'h0000, 8'(cnt), 4'h0, m_ovf, (cnt == 0), (cnt == DEPTH), busy};
      chk("model_tx",  32'(tx),  32'(exp_line(m_ph, m_cur)));
      chk("model_ovf", 32'(ovf), 32'(m_ovf));
      chk("model_hit", 32'(hit), 32'((addr == TX_A) || (addr == ST_A)));
      chk("model_rd",  rd,       exp_rd);
    end
  end

  // ---------------- line receiver: records frame start times and decoded bytes
  logic [7:0] rx_q[$];
  int         fall_q[$];
  int         cyc_cnt = 0;
  int         rx_ph   = -1;
  logic       prev_tx = 1'b1;
  logic [7:0] rx_byte = 8'h00;

  always @(negedge clk) begin : receiver
    cyc_cnt++;
    if (!reset_i) begin
      rx_ph = -1;
    end else begin
      if (rx_ph < 0) begin
        if (prev_tx === 1'b1 && tx === 1'b0) begin
          rx_ph = 0;
          fall_q.push_back(cyc_cnt);
        end
      end else begin
        rx_ph = rx_ph + 1;
      end
      if (rx_ph >= 0) begin
        if ((rx_ph % CPB) == 2 && rx_ph >= CPB + 2 && rx_ph <= 8 * CPB + 2)
          rx_byte[(rx_ph - CPB - 2) / CPB] = tx;
        if (rx_ph == FRAME - 1) begin
          rx_q.push_back(rx_byte);
          rx_ph = -1;
        end
      end
    end
    prev_tx = tx;
  end

  // ---------------- stimulus helpers
  task automatic tick(int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic at_neg();
    @(negedge clk);
    #1;
  endtask

  task automatic store(logic [31:0] a, logic [31:0] d);
    mem_write = 1'b1;
    addr      = a;
    wdata     = d;
    tick(1);
    mem_write = 1'b0;
    addr      = 32'h0;
    wdata     = 32'h0;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  logic [9:0] pat_a5;

  initial begin : stim
    // Reset
    reset_i = 1'b0;
    tick(3);
    reset_i = 1'b1;
    addr    = ST_A;
    at_neg();
    chk("reset_tx",     32'(tx),  32'h1);
    chk("reset_ovf",    32'(ovf), 32'h0);
    chk("reset_status", rd,       32'h0000_0004);
    chk("reset_hit",    32'(hit), 32'h1);

    // Single byte 0xA5: start, LSB-first data, stop
    pat_a5 = {1'b1, 8'hA5, 1'b0};
    rx_q.delete();
    store(TX_A, 32'h0000_00A5);
    at_neg();
    chk("a5_idle_before_start", 32'(tx), 32'h1);
    for (int k = 0; k < 10; k++) begin
      repeat ((k == 0) ? 2 : CPB) at_neg();
      chk("a5_bit", 32'(tx), 32'(pat_a5[k]));
    end
    repeat (8) at_neg();
    chk("a5_line_high_after", 32'(tx), 32'h1);
    chk("a5_rx_count", 32'(rx_q.size()), 32'd1);
    if (rx_q.size() >= 1) chk("a5_rx_byte", 32'(rx_q[0]), 32'h0000_00A5);

    // Back-to-back with upper bits set
    rx_q.delete();
    fall_q.delete();
    store(TX_A, 32'hFFFF_FF41);
    store(TX_A, 32'h0000_0042);
    addr = ST_A;
    tick(80);
    at_neg();
    chk("b2b_busy_in_stop", rd, 32'h0000_0005);
    tick(1);
    at_neg();
    chk("b2b_idle_after", rd, 32'h0000_0004);
    tick(20);
    chk("b2b_rx_count", 32'(rx_q.size()), 32'd2);
    if (rx_q.size() >= 2) begin
      chk("b2b_byte0", 32'(rx_q[0]), 32'h0000_0041);
      chk("b2b_byte1", 32'(rx_q[1]), 32'h0000_0042);
    end
    if (fall_q.size() >= 2) chk("b2b_period", 32'(fall_q[1] - fall_q[0]), 32'd41);

    // Overflow: six consecutive stores, sixth dropped
    rx_q.delete();
    for (int i = 0; i < 6; i++) store(TX_A, 32'(8'h10 + i));
    addr = ST_A;
    at_neg();
    chk("ovf_status", rd,       32'h0000_040B);
    chk("ovf_flag",   32'(ovf), 32'h1);
    tick(260);
    chk("ovf_rx_count", 32'(rx_q.size()), 32'd5);
    if (rx_q.size() >= 5) begin
      chk("ovf_first", 32'(rx_q[0]), 32'h0000_0010);
      chk("ovf_last",  32'(rx_q[4]), 32'h0000_0014);
    end
    at_neg();
    chk("ovf_still_set", 32'(ovf), 32'h1);
    store(ST_A, 32'h0000_0001);
    at_neg();
    chk("ovf_cleared", 32'(ovf), 32'h0);

    // Push on full in the pop cycle
    rx_q.delete();
    store(TX_A, 32'h0000_0020);
    for (int i = 0; i < 4; i++) store(TX_A, 32'(8'h21 + i));
    tick(37);
    store(TX_A, 32'h0000_0099);
    addr = ST_A;
    at_neg();
    chk("full_pop_status", rd,       32'h0000_0403);
    chk("full_pop_ovf",    32'(ovf), 32'h0);
    tick(230);
    chk("full_pop_rx_count", 32'(rx_q.size()), 32'd6);
    if (rx_q.size() >= 6) begin
      chk("full_pop_first", 32'(rx_q[0]), 32'h0000_0020);
      chk("full_pop_last",  32'(rx_q[5]), 32'h0000_0099);
    end

    // Reset in the middle of data bit 3, with a second byte queued
    store(TX_A, 32'h0000_005A);
    store(TX_A, 32'h0000_003C);
    tick(17);
    reset_i = 1'b0;
    addr    = ST_A;
    tick(1);
    reset_i = 1'b1;
    at_neg();
    chk("rst_mid_tx",     32'(tx), 32'h1);
    chk("rst_mid_status", rd,      32'h0000_0004);
    fall_q.delete();
    tick(100);
    chk("rst_mid_no_frames", 32'(fall_q.size()), 32'd0);

    // Address decode
    addr = 32'hFFFF_FF08;
    at_neg();
    chk("dec_hit_other", 32'(hit), 32'h0);
    chk("dec_rd_other",  rd,       32'h0);
    store(32'h0000_0000, 32'h0000_0077);
    addr = ST_A;
    at_neg();
    chk("dec_store_other_status", rd, 32'h0000_0004);
    tick(60);
    chk("dec_store_other_no_frames", 32'(fall_q.size()), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
